// File: rtl/ascii_add_pkg.sv
// Shared constants and FSM state type for the sequential ASCII digit adder.
//   ASCII_ZERO/ASCII_NINE bound the legal digit range, ASCII_ONE is the
//   final carry character, ASCII_ERR marks a beat with an invalid digit.
package ascii_add_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_NINE = 7'h39;
  localparam logic [6:0] ASCII_ONE  = 7'h31;
  localparam logic [6:0] ASCII_ERR  = 7'h3F;

  typedef enum logic {
    S_ACC   = 1'b0,
    S_CARRY = 1'b1
  } state_t;

endpackage

// File: rtl/ascii_digit_add.sv
// Combinational single-digit ASCII adder with BCD correction.
//   i_a, i_b : ASCII operand characters (CHAR_W bits, bits above 7 must be 0)
//   i_cin    : carry in from the previous (less significant) digit
//   o_char   : ASCII sum digit, or ASCII_ERR if either operand is not '0'..'9'
//   o_cout   : carry out to the next digit
//   o_bad    : either operand is outside '0'..'9'
module ascii_digit_add
  import ascii_add_pkg::*;
#(
  parameter int unsigned CHAR_W = 7
) (
  input  logic [CHAR_W-1:0] i_a,
  input  logic [CHAR_W-1:0] i_b,
  input  logic              i_cin,
  output logic [CHAR_W-1:0] o_char,
  output logic              o_cout,
  output logic              o_bad
);

  localparam logic [CHAR_W-1:0] LO = CHAR_W'(ASCII_ZERO);
  localparam logic [CHAR_W-1:0] HI = CHAR_W'(ASCII_NINE);

  logic       w_bad_a;
  logic       w_bad_b;
  logic [3:0] w_da;
  logic [3:0] w_db;
  logic [4:0] w_sum;
  logic [3:0] w_digit;

  always_comb begin
    // Full-width compare so any set upper bit also counts as invalid.
    w_bad_a = (i_a < LO) || (i_a > HI);
    w_bad_b = (i_b < LO) || (i_b > HI);
    // An invalid operand contributes zero but the carry chain keeps running.
    w_da    = w_bad_a ? 4'd0 : 4'(i_a - LO);
    w_db    = w_bad_b ? 4'd0 : 4'(i_b - LO);
    w_sum   = 5'(w_da) + 5'(w_db) + 5'(i_cin);
    if (w_sum >= 5'd10) begin
      w_digit = 4'(w_sum - 5'd10);
      o_cout  = 1'b1;
    end else begin
      w_digit = w_sum[3:0];
      o_cout  = 1'b0;
    end
    o_bad  = w_bad_a || w_bad_b;
    o_char = o_bad ? CHAR_W'(ASCII_ERR) : LO + CHAR_W'(w_digit);
  end

endmodule

// File: rtl/ascii_digit_adder_seq.sv
// Streaming decimal adder: consumes ASCII digit pairs LSD first and emits
// ASCII sum digits LSD first, appending a final '1' when a carry remains.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake for one digit pair
//   in_a, in_b, in_last : operand characters, last = most significant pair
//   out_valid/out_ready : output handshake for one sum character
//   out_char, out_last  : sum character ('?' on invalid digit), frame end
//   out_err             : invalid digit or length overflow seen in this frame
module ascii_digit_adder_seq
  import ascii_add_pkg::*;
#(
  parameter int unsigned CHAR_W     = 7,
  parameter int unsigned MAX_DIGITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_a,
  input  logic [CHAR_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_last,
  output logic              out_err
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  state_t             r_state;
  logic               r_carry;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [CHAR_W-1:0]  r_out_char;
  logic               r_out_last;
  logic               r_out_err;

  state_t             w_state_nxt;
  logic               w_carry_nxt;
  logic               w_err_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ov_nxt;
  logic [CHAR_W-1:0]  w_oc_nxt;
  logic               w_ol_nxt;
  logic               w_oe_nxt;

  logic [CHAR_W-1:0]  w_sum_char;
  logic               w_cout;
  logic               w_bad;
  logic               w_slot_free;
  logic               w_accept;
  logic               w_ovf;
  logic               w_err_beat;
  logic [CNT_W-1:0]   w_cnt_inc;

  ascii_digit_add #(
    .CHAR_W (CHAR_W)
  ) u_digit (
    .i_a    (in_a),
    .i_b    (in_b),
    .i_cin  (r_carry),
    .o_char (w_sum_char),
    .o_cout (w_cout),
    .o_bad  (w_bad)
  );

  // Slot can take a new beat if empty or being drained this cycle.
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == S_ACC) && w_slot_free;
  assign w_accept    = in_valid && in_ready;
  assign w_ovf       = (r_cnt == CNT_MAX);
  assign w_err_beat  = r_err || w_bad || w_ovf;
  assign w_cnt_inc   = w_ovf ? r_cnt : r_cnt + CNT_W'(1);

  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_last  = r_out_last;
  assign out_err   = r_out_err;

  always_comb begin
    w_state_nxt = r_state;
    w_carry_nxt = r_carry;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_ov_nxt    = r_out_valid;
    w_oc_nxt    = r_out_char;
    w_ol_nxt    = r_out_last;
    w_oe_nxt    = r_out_err;

    if (w_slot_free) begin
      w_ov_nxt = 1'b0;
    end

    case (r_state)
      S_ACC: begin
        if (w_accept) begin
          w_ov_nxt = 1'b1;
          w_oc_nxt = w_sum_char;
          w_oe_nxt = w_err_beat;
          if (in_last && w_cout) begin
            // Frame end with carry: the extra '1' beat closes the frame.
            w_state_nxt = S_CARRY;
            w_carry_nxt = 1'b1;
            w_err_nxt   = w_err_beat;
            w_cnt_nxt   = w_cnt_inc;
            w_ol_nxt    = 1'b0;
          end else if (in_last) begin
            w_carry_nxt = 1'b0;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_ol_nxt    = 1'b1;
          end else begin
            w_carry_nxt = w_cout;
            w_err_nxt   = w_err_beat;
            w_cnt_nxt   = w_cnt_inc;
            w_ol_nxt    = 1'b0;
          end
        end
      end
      S_CARRY: begin
        if (w_slot_free) begin
          w_ov_nxt    = 1'b1;
          w_oc_nxt    = CHAR_W'(ASCII_ONE);
          w_ol_nxt    = 1'b1;
          w_oe_nxt    = r_err;
          w_carry_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACC;
        end
      end
      default: begin
        w_state_nxt = S_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACC;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= '0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_carry     <= w_carry_nxt;
      r_err       <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_ov_nxt;
      r_out_char  <= w_oc_nxt;
      r_out_last  <= w_ol_nxt;
      r_out_err   <= w_oe_nxt;
    end
  end

endmodule

// File: tb/tb_ascii_digit_adder_seq.sv
// Self-checking bench for ascii_digit_adder_seq: directed frames plus random
// frames, compared against a digit-by-digit decimal addition model.
module tb_ascii_digit_adder_seq;

  localparam int unsigned CHAR_W     = 7;
  localparam int unsigned MAX_DIGITS = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_a;
  logic [CHAR_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] out_char;
  logic              out_last;
  logic              out_err;

  always #5 clk = ~clk;

  ascii_digit_adder_seq #(
    .CHAR_W     (CHAR_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  typedef struct {
    logic [6:0] c;
    logic       l;
    logic       e;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] fa [0:31];
  logic [6:0] fb [0:31];
  int         flen;
  int         errors = 0;
  int         checks = 0;
  int         ncyc;
  int         nrdy_low;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: schoolbook decimal addition over the frame's characters.
  task automatic model_frame();
    int   carry;
    int   s;
    logic err;
    logic ba;
    logic bb;
    logic be;
    exp_t e;
    carry = 0;
    err   = 1'b0;
    for (int i = 0; i < flen; i++) begin
      ba = !(fa[i] >= 7'h30 && fa[i] <= 7'h39);
      bb = !(fb[i] >= 7'h30 && fb[i] <= 7'h39);
      s  = (ba ? 0 : int'(fa[i]) - 48) + (bb ? 0 : int'(fb[i]) - 48) + carry;
      be = err | ba | bb | (i >= int'(MAX_DIGITS));
      carry = s / 10;
      e.c = (ba | bb) ? 7'h3F : 7'(48 + s % 10);
      e.l = (i == flen - 1) && (carry == 0);
      e.e = be;
      exp_q.push_back(e);
      err = be;
    end
    if (carry != 0) begin
      e.c = 7'h31;
      e.l = 1'b1;
      e.e = err;
      exp_q.push_back(e);
    end
  endtask

  // Drives the frame in fa/fb and drains all expected beats, checking each.
  task automatic run_frame(input int rdy_pct, input int vld_pct);
    int   idx;
    exp_t e;
    model_frame();
    idx      = 0;
    ncyc     = 0;
    nrdy_low = 0;
    while ((idx < flen || exp_q.size() > 0) && ncyc < 2000) begin
      in_valid  = (idx < flen) && ($urandom_range(99) < vld_pct);
      in_a      = fa[idx % 32];
      in_b      = fb[idx % 32];
      in_last   = (idx == flen - 1);
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (!in_ready) nrdy_low++;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({out_char, out_last, out_err}), 32'(prev_beat));
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_char, out_last, out_err};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({out_char, out_last, out_err}), 32'({e.c, e.l, e.e}));
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      ncyc++;
    end
    chk("frame_timeout", 32'(ncyc < 2000), 32'd1);
    exp_q.delete();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic set_pair(input int i, input logic [6:0] a, input logic [6:0] b);
    fa[i] = a;
    fb[i] = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_char", 32'(out_char), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 47 + 85 = 132
    flen = 2; set_pair(0, "7", "5"); set_pair(1, "4", "8");
    run_frame(100, 100);
    chk("t1_cycles", 32'(ncyc), 32'd4);

    // 12 + 34 = 46, no carry beat, never stalls input
    flen = 2; set_pair(0, "2", "4"); set_pair(1, "1", "3");
    run_frame(100, 100);
    chk("t2_cycles", 32'(ncyc), 32'd3);
    chk("t2_in_ready_low", 32'(nrdy_low), 32'd0);

    // invalid digit, then a clean frame
    flen = 2; set_pair(0, "A", "1"); set_pair(1, "9", "9");
    run_frame(100, 100);
    flen = 1; set_pair(0, "1", "1");
    run_frame(100, 100);

    // backpressure on a 16-digit frame
    flen = 16;
    for (int i = 0; i < 16; i++) set_pair(i, "9", "0");
    run_frame(30, 100);

    // length overflow on the 17th pair
    flen = 17;
    for (int i = 0; i < 17; i++) set_pair(i, "1", "1");
    run_frame(100, 100);

    // async reset mid-frame with carry pending
    in_valid  = 1'b1;
    in_a      = "9";
    in_b      = "9";
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_char", 32'(out_char), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    flen = 1; set_pair(0, "5", "5");
    run_frame(100, 100);

    // random frames, some invalid characters and some overlong
    for (int f = 0; f < 25; f++) begin
      flen = int'($urandom_range(20, 1));
      for (int i = 0; i < flen; i++) begin
        fa[i] = ($urandom_range(9) == 0) ? 7'($urandom_range(127)) : 7'(48 + $urandom_range(9));
        fb[i] = ($urandom_range(9) == 0) ? 7'($urandom_range(127)) : 7'(48 + $urandom_range(9));
      end
      run_frame(60, 80);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
